id_issue_stage: RTL and testbench

Parametrised registered issue stage between the combinational decoder and EX. It resolves both source operands across NFWD forwarding sources and detects load-use hazards against pending (not-yet-available) results. It also interlocks multi-cycle MUL ops and presents a valid/ready registered bundle to EX. It replaces the purely combinational ID-stage forwarding and stall path.

---
 rtl/id_issue_stage.sv | 150 +++++++++++++++
 tb/tb_id_issue_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/id_issue_stage.sv
// rtl/id_issue_stage.sv - registered ID issue stage: operand forwarding, load-use/MUL interlock, valid/ready to EX
// Optional feature macro: ID_ISSUE_PERF_EN (adds perf_stall_cnt / perf_issue_cnt)
module id_issue_stage #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int NFWD    = 2,
  parameter int MUL_LAT = 3,
  parameter int CW      = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AW-1:0]        in_raddr1,
  input  logic [AW-1:0]        in_raddr2,
  input  logic                 in_re1,
  input  logic                 in_re2,
  input  logic [DW-1:0]        in_imm,
  input  logic                 in_use_imm2,
  input  logic [AW-1:0]        in_waddr,
  input  logic                 in_we,
  input  logic                 in_is_load,
  input  logic                 in_is_mul,
  input  logic [CW-1:0]        in_ctrl,
  input  logic [DW-1:0]        rdata1,
  input  logic [DW-1:0]        rdata2,
  input  logic [NFWD-1:0]      fwd_we,
  input  logic [NFWD*AW-1:0]   fwd_waddr,
  input  logic [NFWD*DW-1:0]   fwd_wdata,
  input  logic [NFWD-1:0]      fwd_pending,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_op1,
  output logic [DW-1:0]        out_op2,
  output logic [AW-1:0]        out_waddr,
  output logic                 out_we,
  output logic                 out_is_load,
  output logic [CW-1:0]        out_ctrl,
`ifdef ID_ISSUE_PERF_EN
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_issue_cnt,
`endif
  output logic                 stall_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;
  localparam int CNTW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic MUL_MULTI = (MUL_LAT > 1);

  logic [0:0]      state;
  logic [CNTW-1:0] cnt;
  logic [DW:0]     res1;
  logic [DW:0]     res2;
  logic            hazard;
  logic            accept;

  // Returns {hazard, value}; the youngest matching forwarding source wins.
  function automatic logic [DW:0] resolve_port(input logic [AW-1:0] addr, input logic re,
                                               input logic [DW-1:0] rdata, input logic [DW-1:0] dflt);
    logic [DW-1:0] val;
    logic          haz;
    logic          found;
    val   = rdata;
    haz   = 1'b0;
    found = 1'b0;
    if (!re) begin
      val = dflt;
    end else if (addr == '0) begin
      val = '0;
    end else begin
      for (int i = 0; i < NFWD; i++) begin
        if (!found && fwd_we[i] && (fwd_waddr[i*AW +: AW] == addr)) begin
          found = 1'b1;
          haz   = fwd_pending[i];
          val   = fwd_wdata[i*DW +: DW];
        end
      end
    end
    return {haz, val};
  endfunction

  // Resolve both operands and derive the issue handshake.
  always_comb begin
    res1     = resolve_port(in_raddr1, in_re1, rdata1, '0);
    res2     = resolve_port(in_raddr2, in_re2, rdata2, in_use_imm2 ? in_imm : '0);
    hazard   = in_valid & (res1[DW] | res2[DW]);
    in_ready = ~rst & ~flush & ~hazard & (state == S_IDLE) & (~out_valid | out_ready);
    accept   = in_valid & in_ready;
    stall_o  = in_valid & ~in_ready;
  end

  // Output bundle register and MUL occupancy FSM; flush squashes everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_op1     <= '0;
      out_op2     <= '0;
      out_waddr   <= '0;
      out_we      <= 1'b0;
      out_is_load <= 1'b0;
      out_ctrl    <= '0;
      state       <= S_IDLE;
      cnt         <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      state     <= S_IDLE;
      cnt       <= '0;
    end else begin
      if (accept) begin
        out_valid   <= 1'b1;
        out_op1     <= res1[DW-1:0];
        out_op2     <= res2[DW-1:0];
        out_waddr   <= in_waddr;
        out_we      <= in_we;
        out_is_load <= in_is_load;
        out_ctrl    <= in_ctrl;
        if (in_is_mul && MUL_MULTI) begin
          state <= S_BUSY;
          cnt   <= CNTW'(MUL_LAT - 1);
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (state == S_BUSY) begin
        if (cnt == CNTW'(1)) begin
          state <= S_IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt - CNTW'(1);
        end
      end
    end
  end

`ifdef ID_ISSUE_PERF_EN
  // Saturating stall and issue counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_issue_cnt <= '0;
    end else begin
      if (stall_o && perf_stall_cnt != 32'hFFFF_FFFF) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (accept && perf_issue_cnt != 32'hFFFF_FFFF) perf_issue_cnt <= perf_issue_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_issue_stage.sv
// tb/tb_id_issue_stage.sv - self-checking bench for id_issue_stage against a behavioural model
module tb_id_issue_stage;
  localparam int DW = 32, AW = 5, NF = 2, ML = 3, CW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, in_ready, in_re1, in_re2, in_use_imm2, in_we, in_is_load, in_is_mul;
  logic [AW-1:0] in_raddr1, in_raddr2, in_waddr;
  logic [DW-1:0] in_imm, rdata1, rdata2;
  logic [CW-1:0] in_ctrl;
  logic [NF-1:0] fwd_we, fwd_pending;
  logic [NF*AW-1:0] fwd_waddr;
  logic [NF*DW-1:0] fwd_wdata;
  logic flush, out_valid, out_ready, out_we, out_is_load, stall_o;
  logic [DW-1:0] out_op1, out_op2;
  logic [AW-1:0] out_waddr;
  logic [CW-1:0] out_ctrl;

  id_issue_stage #(.DW(DW), .AW(AW), .NFWD(NF), .MUL_LAT(ML), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_raddr1(in_raddr1), .in_raddr2(in_raddr2), .in_re1(in_re1), .in_re2(in_re2),
    .in_imm(in_imm), .in_use_imm2(in_use_imm2), .in_waddr(in_waddr), .in_we(in_we),
    .in_is_load(in_is_load), .in_is_mul(in_is_mul), .in_ctrl(in_ctrl),
    .rdata1(rdata1), .rdata2(rdata2), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr),
    .fwd_wdata(fwd_wdata), .fwd_pending(fwd_pending), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1), .out_op2(out_op2),
    .out_waddr(out_waddr), .out_we(out_we), .out_is_load(out_is_load), .out_ctrl(out_ctrl),
    .stall_o(stall_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic          m_valid, m_we, m_load;
  logic [DW-1:0] m_op1, m_op2;
  logic [AW-1:0] m_waddr;
  logic [CW-1:0] m_ctrl;
  int            m_wait;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Walk sources oldest to youngest so the youngest match is the one left standing.
  function automatic void ref_op(input logic [AW-1:0] a, input logic re, input logic [DW-1:0] rd,
                                 input logic [DW-1:0] dflt, output logic [DW-1:0] v, output logic h);
    h = 1'b0;
    if (!re) v = dflt;
    else if (a == 0) v = '0;
    else begin
      v = rd;
      for (int i = NF - 1; i >= 0; i--)
        if (fwd_we[i] && fwd_waddr[i*AW +: AW] == a) begin
          v = fwd_wdata[i*DW +: DW];
          h = fwd_pending[i];
        end
    end
  endfunction

  // One clock: check combinational handshake, step the model, check registered outputs.
  task automatic cycle();
    logic [DW-1:0] v1, v2;
    logic h1, h2, e_rdy, e_acc;
    #1;
    ref_op(in_raddr1, in_re1, rdata1, '0, v1, h1);
    ref_op(in_raddr2, in_re2, rdata2, in_use_imm2 ? in_imm : '0, v2, h2);
    e_rdy = !rst && !flush && !(in_valid && (h1 || h2)) && (m_wait == 0) && (!m_valid || out_ready);
    e_acc = in_valid && e_rdy;
    chk("in_ready", {63'd0, in_ready}, {63'd0, e_rdy});
    chk("stall_o", {63'd0, stall_o}, {63'd0, in_valid && !e_rdy});
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_we = 0; m_load = 0; m_op1 = 0; m_op2 = 0; m_waddr = 0; m_ctrl = 0; m_wait = 0;
    end else if (flush) begin
      m_valid = 0; m_wait = 0;
    end else begin
      if (m_wait > 0) m_wait--;
      if (e_acc) begin
        m_valid = 1; m_op1 = v1; m_op2 = v2; m_waddr = in_waddr; m_we = in_we;
        m_load = in_is_load; m_ctrl = in_ctrl;
        if (in_is_mul) m_wait = ML - 1;
      end else if (m_valid && out_ready) m_valid = 0;
    end
    @(negedge clk);
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    chk("out_op1", {32'd0, out_op1}, {32'd0, m_op1});
    chk("out_op2", {32'd0, out_op2}, {32'd0, m_op2});
    chk("out_waddr", {59'd0, out_waddr}, {59'd0, m_waddr});
    chk("out_we", {63'd0, out_we}, {63'd0, m_we});
    chk("out_is_load", {63'd0, out_is_load}, {63'd0, m_load});
    chk("out_ctrl", {52'd0, out_ctrl}, {52'd0, m_ctrl});
  endtask

  task automatic quiet();
    rst = 0; in_valid = 0; in_raddr1 = 0; in_raddr2 = 0; in_re1 = 0; in_re2 = 0; in_imm = 0;
    in_use_imm2 = 0; in_waddr = 0; in_we = 0; in_is_load = 0; in_is_mul = 0; in_ctrl = 0;
    rdata1 = 0; rdata2 = 0; fwd_we = 0; fwd_waddr = 0; fwd_wdata = 0; fwd_pending = 0;
    flush = 0; out_ready = 1;
  endtask

  initial begin
    m_valid = 0; m_we = 0; m_load = 0; m_op1 = 0; m_op2 = 0; m_waddr = 0; m_ctrl = 0; m_wait = 0;
    quiet();
    rst = 1; flush = 1;
    cycle(); cycle();
    chk("reset_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_ctrl", {52'd0, out_ctrl}, 64'd0);
    quiet();
    cycle();

    // 1: forward priority, youngest source wins over older source and regfile
    in_valid = 1; in_re1 = 1; in_raddr1 = 3; rdata1 = 32'h11; in_ctrl = 12'h123;
    fwd_we = 2'b11; fwd_waddr = {5'd3, 5'd3}; fwd_wdata = {32'hBB, 32'hAA};
    cycle();
    chk("t1_op1", {32'd0, out_op1}, 64'hAA);

    // 2: load-use on port 2 stalls one cycle, then forwards the loaded data
    quiet();
    in_valid = 1; in_re2 = 1; in_raddr2 = 5; rdata2 = 32'h77;
    fwd_we = 2'b01; fwd_waddr = {5'd0, 5'd5}; fwd_wdata = {32'h0, 32'hC0DE}; fwd_pending = 2'b01;
    #1 chk("t2_stall", {63'd0, stall_o}, 64'd1);
    cycle();
    chk("t2_bubble", {63'd0, out_valid}, 64'd0);
    fwd_pending = 0;
    cycle();
    chk("t2_op2", {32'd0, out_op2}, 64'hC0DE);

    // 3: MUL interlock blocks for MUL_LAT-1 cycles
    quiet();
    in_valid = 1; in_is_mul = 1; in_ctrl = 12'h3A1;
    cycle();
    in_is_mul = 0; in_ctrl = 12'h3A2;
    chk("t3_blk1", {63'd0, in_ready}, 64'd0);
    cycle();
    chk("t3_blk2", {63'd0, in_ready}, 64'd0);
    cycle();
    chk("t3_free", {63'd0, in_ready}, 64'd1);
    cycle();
    chk("t3_ctrl", {52'd0, out_ctrl}, 64'h3A2);

    // 4: back-pressure holds the bundle; release accepts the next instruction at once
    quiet();
    cycle();
    in_valid = 1; in_re1 = 1; in_raddr1 = 9; rdata1 = 32'h1234; in_ctrl = 12'h5A5; out_ready = 0;
    cycle();
    for (int k = 0; k < 4; k++) begin
      in_ctrl = 12'h0F0 + 12'(k); rdata1 = 32'h9000 + k;
      cycle();
      chk("t4_hold_op1", {32'd0, out_op1}, 64'h1234);
      chk("t4_hold_ctrl", {52'd0, out_ctrl}, 64'h5A5);
    end
    in_ctrl = 12'h6B6; out_ready = 1;
    cycle();
    chk("t4_next_ctrl", {52'd0, out_ctrl}, 64'h6B6);

    // 5: flush on the first busy cycle
    quiet();
    in_valid = 1; in_is_mul = 1;
    cycle();
    in_is_mul = 0; flush = 1;
    cycle();
    flush = 0;
    #1;
    chk("t5_valid", {63'd0, out_valid}, 64'd0);
    chk("t5_ready", {63'd0, in_ready}, 64'd1);
    cycle();

    // 6: register zero never forwards or stalls
    quiet();
    in_valid = 1; in_re1 = 1; in_raddr1 = 0; rdata1 = 32'hDEAD;
    fwd_we = 2'b01; fwd_waddr = 0; fwd_wdata = {32'h0, 32'hBEEF}; fwd_pending = 2'b01;
    #1 chk("t6_nostall", {63'd0, stall_o}, 64'd0);
    cycle();
    chk("t6_op1", {32'd0, out_op1}, 64'd0);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 29) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_raddr1 = AW'($urandom_range(0, 3)); in_raddr2 = AW'($urandom_range(0, 3));
      in_re1 = $urandom_range(0, 1); in_re2 = $urandom_range(0, 1);
      in_imm = $urandom(); in_use_imm2 = $urandom_range(0, 1);
      in_waddr = AW'($urandom()); in_we = $urandom_range(0, 1);
      in_is_load = $urandom_range(0, 1); in_is_mul = ($urandom_range(0, 4) == 0);
      in_ctrl = CW'($urandom()); rdata1 = $urandom(); rdata2 = $urandom();
      fwd_we = NF'($urandom()); fwd_waddr = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      fwd_wdata = {$urandom(), $urandom()};
      fwd_pending = ($urandom_range(0, 3) == 0) ? NF'($urandom()) : '0;
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
